// File: rtl/bus_bridge_if.sv
// CPU data-bus bundle between the MEM stage (master) and the bus bridge (slave).
interface bus_bridge_if;
  logic [31:0] Bus_addr;
  logic        Bus_wen;
  logic [31:0] Bus_wdata;
  logic [31:0] Bus_rdata;

  modport master (output Bus_addr, output Bus_wen, output Bus_wdata, input Bus_rdata);
  modport slave  (input Bus_addr, input Bus_wen, input Bus_wdata, output Bus_rdata);
endinterface

// File: rtl/bus_bridge.sv
// Bus bridge: decodes the CPU data bus onto the data RAM and a 4 KB peripheral
// page holding the display word, LED register, synchronised switches/buttons
// and a prescaled 32-bit timer. Also scans the 8-digit 7-segment display.
module bus_bridge #(
  parameter int          DRAM_AW     = 14,
  parameter logic [15:0] SCAN_DIV    = 16'd20000,
  parameter logic [31:0] PERIPH_BASE = 32'hFFFF_F000
) (
  input  logic               cpu_clk,
  input  logic               cpu_rst_n,
  bus_bridge_if.slave        bus,
  output logic [DRAM_AW-1:0] dram_addr,
  output logic               dram_wen,
  output logic [31:0]        dram_wdata,
  input  logic [31:0]        dram_rdata,
  input  logic [23:0]        sw,
  input  logic [4:0]         btn,
  output logic [23:0]        led,
  output logic [7:0]         dig_en,
  output logic [7:0]         dig_seg
);

  localparam logic [11:0] OFF_DIG  = 12'h000;
  localparam logic [11:0] OFF_TCNT = 12'h020;
  localparam logic [11:0] OFF_TPRE = 12'h024;
  localparam logic [11:0] OFF_LED  = 12'h060;
  localparam logic [11:0] OFF_SW   = 12'h070;
  localparam logic [11:0] OFF_BTN  = 12'h078;

  // Active-low 7-segment glyph {dp,g,f,e,d,c,b,a} for one hex nibble, dp off.
  function automatic logic [7:0] glyph(input logic [3:0] nib);
    logic [7:0] g;
    case (nib)
      4'h0: g = 8'hC0;  4'h1: g = 8'hF9;  4'h2: g = 8'hA4;  4'h3: g = 8'hB0;
      4'h4: g = 8'h99;  4'h5: g = 8'h92;  4'h6: g = 8'h82;  4'h7: g = 8'hF8;
      4'h8: g = 8'h80;  4'h9: g = 8'h90;  4'hA: g = 8'h88;  4'hB: g = 8'h83;
      4'hC: g = 8'hC6;  4'hD: g = 8'hA1;  4'hE: g = 8'h86;  default: g = 8'h8E;
    endcase
    return g;
  endfunction

  // Peripheral state.
  logic [31:0] dig;
  logic [31:0] tcnt;
  logic [31:0] tpre;
  logic [31:0] pc;
  logic [15:0] scan_cnt;
  logic [2:0]  idx;
  logic [23:0] sw_meta, sw_sync;
  logic [4:0]  btn_meta, btn_sync;
  logic [31:0] rdata;

  // Address decode.
  logic        is_periph;
  logic [11:0] offset;
  logic        periph_wen;
  logic        wr_dig, wr_tcnt, wr_tpre, wr_led;

  assign is_periph  = (bus.Bus_addr >= PERIPH_BASE);
  assign offset     = bus.Bus_addr[11:0];
  assign periph_wen = bus.Bus_wen & is_periph;
  assign wr_dig     = periph_wen && (offset == OFF_DIG);
  assign wr_tcnt    = periph_wen && (offset == OFF_TCNT);
  assign wr_tpre    = periph_wen && (offset == OFF_TPRE);
  assign wr_led     = periph_wen && (offset == OFF_LED);

  // RAM side is a straight pass-through, gated only by the decode.
  assign dram_addr  = bus.Bus_addr[DRAM_AW+1:2];
  assign dram_wen   = bus.Bus_wen & ~is_periph;
  assign dram_wdata = bus.Bus_wdata;

  // Combinational read mux: the CPU samples this in the same MEM cycle.
  always_comb begin
    // NOTE: default every output of a combinational block first so no path leaves it unassigned (latch).
    rdata = '0;
    if (!is_periph) begin
      rdata = dram_rdata;
    end else begin
      case (offset)
        OFF_DIG:  rdata = dig;
        OFF_TCNT: rdata = tcnt;
        OFF_TPRE: rdata = tpre;
        OFF_LED:  rdata = {8'b0, led};
        OFF_SW:   rdata = {8'b0, sw_sync};
        OFF_BTN:  rdata = {27'b0, btn_sync};
        default:  rdata = '0;
      endcase
    end
  end

  assign bus.Bus_rdata = rdata;

  // Two-flop synchronisers for the asynchronous switch and button pins.
  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      sw_meta  <= '0;
      sw_sync  <= '0;
      btn_meta <= '0;
      btn_sync <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      sw_meta  <= sw;
      sw_sync  <= sw_meta;
      btn_meta <= btn;
      btn_sync <= btn_meta;
    end
  end

  // LED register.
  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      led <= '0;
    end else if (wr_led) begin
      led <= bus.Bus_wdata[23:0];
    end
  end

  // Timer: pc counts 0..tpre; each rollover bumps tcnt. A CPU write to tcnt
  // beats a same-cycle increment; writes to either register restart pc.
  logic tick;
  assign tick = (pc == tpre);

  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      tcnt <= '0;
      tpre <= '0;
      pc   <= '0;
    end else begin
      if (wr_tcnt) begin
        tcnt <= bus.Bus_wdata;
      end else if (tick) begin
        tcnt <= tcnt + 32'd1;
      end
      if (wr_tpre) begin
        tpre <= bus.Bus_wdata;
      end
      if (wr_tcnt || wr_tpre || tick) begin
        pc <= '0;
      end else begin
        pc <= pc + 32'd1;
      end
    end
  end

  // Display scan: registered digit outputs are built from next-state idx and
  // DIG, so a DIG write shows on the current digit the cycle after the write.
  logic        scan_wrap;
  logic [2:0]  idx_next;
  logic [31:0] dig_next;

  assign scan_wrap = (scan_cnt == SCAN_DIV - 16'd1);
  assign idx_next  = scan_wrap ? idx + 3'd1 : idx;
  assign dig_next  = wr_dig ? bus.Bus_wdata : dig;

  // Scan counter, digit index, display word and the registered digit drivers.
  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      scan_cnt <= '0;
      idx      <= '0;
      dig      <= '0;
      dig_en   <= 8'hFE;
      dig_seg  <= 8'hC0;
    end else begin
      scan_cnt <= scan_wrap ? 16'd0 : scan_cnt + 16'd1;
      idx      <= idx_next;
      dig      <= dig_next;
      dig_en   <= ~(8'b1 << idx_next);
      dig_seg  <= glyph(dig_next[{idx_next, 2'b00} +: 4]);
    end
  end

endmodule

// File: tb/tb_bus_bridge.sv
// Self-checking bench for bus_bridge: directed steps followed by random bus
// traffic, compared against a behavioural model of the peripheral page.
module tb_bus_bridge;

  localparam logic [31:0] BASE = 32'hFFFF_F000;
  localparam int          SCAN = 4;
  localparam logic [7:0]  GLYPH [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  logic        cpu_clk = 1'b0;
  logic        cpu_rst_n;
  logic [13:0] dram_addr;
  logic        dram_wen;
  logic [31:0] dram_wdata;
  logic [31:0] dram_rdata;
  logic [23:0] sw;
  logic [4:0]  btn;
  logic [23:0] led;
  logic [7:0]  dig_en;
  logic [7:0]  dig_seg;

  int n_checks = 0;
  int n_fail   = 0;

  bus_bridge_if bus ();

  bus_bridge #(.DRAM_AW(14), .SCAN_DIV(16'(SCAN)), .PERIPH_BASE(BASE)) dut (
    .cpu_clk    (cpu_clk),
    .cpu_rst_n  (cpu_rst_n),
    .bus        (bus),
    .dram_addr  (dram_addr),
    .dram_wen   (dram_wen),
    .dram_wdata (dram_wdata),
    .dram_rdata (dram_rdata),
    .sw         (sw),
    .btn        (btn),
    .led        (led),
    .dig_en     (dig_en),
    .dig_seg    (dig_seg)
  );

  always #5 cpu_clk = ~cpu_clk;

  // Reference model state.
  logic [31:0] m_dig, m_tcnt, m_tpre, m_pc;
  logic [23:0] m_led, m_sw1, m_sw2;
  logic [4:0]  m_btn1, m_btn2;
  int          m_edges;

  task automatic model_reset();
    m_dig = '0; m_tcnt = '0; m_tpre = '0; m_pc = '0; m_led = '0;
    m_sw1 = '0; m_sw2 = '0; m_btn1 = '0; m_btn2 = '0; m_edges = 0;
  endtask

  // One clock edge of the architectural behaviour, using the inputs held this cycle.
  task automatic model_edge();
    logic        pw, wt, wp, roll;
    logic [11:0] off;
    logic [31:0] wd;
    off  = bus.Bus_addr[11:0];
    wd   = bus.Bus_wdata;
    pw   = bus.Bus_wen && (bus.Bus_addr >= BASE);
    wt   = pw && (off == 12'h020);
    wp   = pw && (off == 12'h024);
    roll = (m_pc == m_tpre);
    if (wt) m_tcnt = wd;
    else if (roll) m_tcnt = m_tcnt + 32'd1;
    if (wp) m_tpre = wd;
    m_pc = (wt || wp || roll) ? 32'd0 : m_pc + 32'd1;
    if (pw && off == 12'h000) m_dig = wd;
    if (pw && off == 12'h060) m_led = wd[23:0];
    m_sw2 = m_sw1;   m_sw1 = sw;
    m_btn2 = m_btn1; m_btn1 = btn;
    m_edges++;
  endtask

  function automatic logic [31:0] exp_rdata();
    if (bus.Bus_addr < BASE) return dram_rdata;
    case (bus.Bus_addr[11:0])
      12'h000: return m_dig;
      12'h020: return m_tcnt;
      12'h024: return m_tpre;
      12'h060: return {8'b0, m_led};
      12'h070: return {8'b0, m_sw2};
      12'h078: return {27'b0, m_btn2};
      default: return 32'd0;
    endcase
  endfunction

  // The digit on show is the edge count divided into SCAN-cycle slots, mod 8.
  function automatic int exp_idx();
    return (m_edges / SCAN) % 8;
  endfunction

  function automatic logic [7:0] exp_en();
    return ~(8'b1 << exp_idx());
  endfunction

  function automatic logic [7:0] exp_seg();
    return GLYPH[m_dig[4*exp_idx() +: 4]];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".rdata"}, bus.Bus_rdata, exp_rdata());
    check({tag, ".dram_wen"}, {31'b0, dram_wen},
          {31'b0, (bus.Bus_addr < BASE) ? bus.Bus_wen : 1'b0});
    check({tag, ".dram_addr"}, {18'b0, dram_addr}, (bus.Bus_addr >> 2) & 32'h3FFF);
    check({tag, ".dram_wdata"}, dram_wdata, bus.Bus_wdata);
    check({tag, ".led"}, {8'b0, led}, {8'b0, m_led});
    check({tag, ".dig_en"}, {24'b0, dig_en}, {24'b0, exp_en()});
    check({tag, ".dig_seg"}, {24'b0, dig_seg}, {24'b0, exp_seg()});
  endtask

  // Set bus inputs (called at a falling edge) and let combinational outputs settle.
  task automatic drive(input logic [31:0] addr, input logic wen, input logic [31:0] wdata);
    bus.Bus_addr  = addr;
    bus.Bus_wen   = wen;
    bus.Bus_wdata = wdata;
    dram_rdata    = $urandom;
    #1;
  endtask

  // Advance one rising edge (updating the model) and return just after the falling edge.
  task automatic step();
    @(posedge cpu_clk);
    if (cpu_rst_n) model_edge();
    @(negedge cpu_clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    logic [31:0] addr, wd;
    int          sel;
    logic        wen;

    cpu_rst_n = 1'b0;
    sw = '0; btn = '0;
    model_reset();
    bus.Bus_addr = '0; bus.Bus_wen = 1'b1; bus.Bus_wdata = '0; dram_rdata = '0;
    @(negedge cpu_clk);
    drive(BASE + 32'h020, 1'b0, 32'd0);

    // Reset state.
    check("rst.led", {8'b0, led}, 32'd0);
    check("rst.dig_en", {24'b0, dig_en}, 32'hFE);
    check("rst.dig_seg", {24'b0, dig_seg}, 32'hC0);
    check("rst.tcnt", bus.Bus_rdata, 32'd0);
    drive(32'h0000_0010, 1'b1, 32'h1234_5678);
    check("rst.dram_wen_follows", {31'b0, dram_wen}, 32'd1);
    drive(32'h0, 1'b0, 32'h0);
    steps(2);
    cpu_rst_n = 1'b1;
    #1;

    // DRAM access.
    drive(32'h0000_0104, 1'b1, 32'hDEAD_BEEF);
    check("dram.addr", {18'b0, dram_addr}, 32'h41);
    check("dram.wen", {31'b0, dram_wen}, 32'd1);
    check("dram.wdata", dram_wdata, 32'hDEAD_BEEF);
    check_all("dram");
    step();
    drive(BASE + 32'h060, 1'b0, 32'h0);
    check("periph.dram_wen", {31'b0, dram_wen}, 32'd0);

    // LED write and readback.
    drive(BASE + 32'h060, 1'b1, 32'hFFAB_CDEF);
    check("led.wr_dram_wen", {31'b0, dram_wen}, 32'd0);
    step();
    drive(BASE + 32'h060, 1'b0, 32'h0);
    check("led.out", {8'b0, led}, 32'h00AB_CDEF);
    check("led.read", bus.Bus_rdata, 32'h00AB_CDEF);

    // Switch synchroniser latency.
    sw = 24'h123456;
    drive(BASE + 32'h070, 1'b0, 32'h0);
    check("sw.edge0", bus.Bus_rdata, 32'h0);
    step();
    check("sw.edge1", bus.Bus_rdata, 32'h0);
    step();
    check("sw.edge2", bus.Bus_rdata, 32'h0012_3456);
    check_all("sw");
    btn = 5'h15;
    steps(2);
    drive(BASE + 32'h078, 1'b0, 32'h0);
    check("btn.read", bus.Bus_rdata, 32'h15);

    // Timer: prescale 3, so TCNT advances every 4 cycles.
    drive(BASE + 32'h024, 1'b1, 32'd3);
    step();
    drive(BASE + 32'h020, 1'b1, 32'd100);
    step();
    drive(BASE + 32'h020, 1'b0, 32'h0);
    check("tmr.after_wr", bus.Bus_rdata, 32'd100);
    steps(3);
    check("tmr.3cyc", bus.Bus_rdata, 32'd100);
    step();
    check("tmr.4cyc", bus.Bus_rdata, 32'd101);
    steps(4);
    check("tmr.8cyc", bus.Bus_rdata, 32'd102);
    check_all("tmr");

    // Timer wrap from all-ones.
    drive(BASE + 32'h020, 1'b1, 32'hFFFF_FFFF);
    step();
    drive(BASE + 32'h020, 1'b0, 32'h0);
    check("wrap.wr", bus.Bus_rdata, 32'hFFFF_FFFF);
    steps(3);
    check("wrap.3cyc", bus.Bus_rdata, 32'hFFFF_FFFF);
    step();
    check("wrap.4cyc", bus.Bus_rdata, 32'd0);

    // Write on an increment cycle: prescaler is at TPRE after 3 more edges.
    steps(3);
    drive(BASE + 32'h020, 1'b1, 32'h55);
    step();
    drive(BASE + 32'h020, 1'b0, 32'h0);
    check("collide.kept", bus.Bus_rdata, 32'h55);
    steps(3);
    check("collide.3cyc", bus.Bus_rdata, 32'h55);
    step();
    check("collide.4cyc", bus.Bus_rdata, 32'h56);

    // Display scan from a fresh reset so slot timing is known.
    cpu_rst_n = 1'b0;
    #1;
    model_reset();
    check("rst2.led", {8'b0, led}, 32'd0);
    check("rst2.dig_en", {24'b0, dig_en}, 32'hFE);
    step();
    cpu_rst_n = 1'b1;
    drive(BASE + 32'h000, 1'b1, 32'h7654_3210);
    step();
    drive(BASE + 32'h000, 1'b0, 32'h0);
    for (int k = 1; k <= 36; k++) begin
      check("scan.en", {24'b0, dig_en}, {24'b0, ~(8'b1 << ((k / SCAN) % 8))});
      check("scan.seg", {24'b0, dig_seg}, {24'b0, GLYPH[(k / SCAN) % 8]});
      step();
    end
    check_all("scan");

    // Unmapped offset: reads zero, writes change nothing.
    drive(BASE + 32'h100, 1'b0, 32'h0);
    check("unmap.read", bus.Bus_rdata, 32'h0);
    drive(BASE + 32'h100, 1'b1, 32'hCAFE_F00D);
    check("unmap.dram_wen", {31'b0, dram_wen}, 32'd0);
    check("unmap.read_wen", bus.Bus_rdata, 32'h0);
    step();
    drive(BASE + 32'h000, 1'b0, 32'h0);
    check("unmap.dig", bus.Bus_rdata, 32'h7654_3210);
    check("unmap.led", {8'b0, led}, 32'd0);
    check_all("unmap");

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      sel = int'($urandom_range(0, 10));
      wen = 1'($urandom_range(0, 1));
      wd  = $urandom;
      case (sel)
        0, 1, 2: addr = $urandom & 32'h7FFF_FFFF;
        3:  addr = BASE + 32'h000;
        4:  addr = BASE + 32'h020;
        5:  begin addr = BASE + 32'h024; wd = $urandom_range(0, 5); end
        6:  addr = BASE + 32'h060;
        7:  addr = BASE + 32'h070;
        8:  addr = BASE + 32'h078;
        9:  addr = BASE + 32'h004;
        default: addr = BASE + 32'hFFC;
      endcase
      if ($urandom_range(0, 3) == 0) sw = 24'($urandom);
      if ($urandom_range(0, 3) == 0) btn = 5'($urandom);
      drive(addr, wen, wd);
      check_all("rand");
      step();
    end

    // Reset asserted while a write is pending discards that write.
    drive(BASE + 32'h060, 1'b1, 32'h00FF_FFFF);
    cpu_rst_n = 1'b0;
    #1;
    model_reset();
    check("rstw.led", {8'b0, led}, 32'd0);
    step();
    drive(BASE + 32'h060, 1'b0, 32'h0);
    cpu_rst_n = 1'b1;
    #1;
    check("rstw.read", bus.Bus_rdata, 32'd0);
    check_all("rstw");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
